// File: rtl/syn_lb_pkg.sv
// syn_lb_pkg: shared types and constants for the local-bus address decoder.
package syn_lb_pkg;

    // Decoder transaction sequencing.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } lb_dec_fsm_t;

    // Kind of the captured transaction.
    typedef enum logic {
        LB_RD = 1'b0,
        LB_WR = 1'b1
    } lb_txn_t;

    // Read data returned with an error response; wide enough for any DATA_W,
    // users size-cast it down to their data width.
    localparam int unsigned              LB_ERR_DATA_W = 1024;
    localparam logic [LB_ERR_DATA_W-1:0] LB_ERR_DATA   = '0;

endpackage : syn_lb_pkg

// File: rtl/syn_lb_addr_dec.sv
// syn_lb_addr_dec: local-bus slave-side decoder. Accepts one lb read/write at
// a time, decodes the upper SEL_W address bits to a slave index, forwards a
// one-cycle enable pulse to that slave, waits for its ack and returns a
// one-cycle valid (with read data / error) to the master.
// Optional build macro: SYN_LB_DEC_TIMEOUT_EN adds a wait-state timeout of
// TIMEOUT_CYC cycles that ends the transaction with an error response.
module syn_lb_addr_dec
    import syn_lb_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 12,
    parameter int SEL_W       = 4,
    parameter int NUM_SL      = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                      clk_ir,
    input  logic                      rst_il,
    input  logic                      lb_rd_en_i,
    input  logic                      lb_wr_en_i,
    input  logic [ADDR_W-1:0]         lb_addr_i,
    input  logic [DATA_W-1:0]         lb_wr_data_i,
    output logic                      lb_wr_valid_o,
    output logic                      lb_rd_valid_o,
    output logic [DATA_W-1:0]         lb_rd_data_o,
    output logic                      lb_err_o,
    output logic                      lb_busy_o,
    output logic [NUM_SL-1:0]         sl_rd_en_o,
    output logic [NUM_SL-1:0]         sl_wr_en_o,
    output logic [ADDR_W-SEL_W-1:0]   sl_addr_o,
    output logic [DATA_W-1:0]         sl_wr_data_o,
    input  logic [NUM_SL-1:0]         sl_wr_valid_i,
    input  logic [NUM_SL-1:0]         sl_rd_valid_i,
    input  logic [NUM_SL*DATA_W-1:0]  sl_rd_data_i
);

    localparam int               SLA_W    = ADDR_W - SEL_W;
    localparam logic [SEL_W:0]   NUM_SL_V = (SEL_W + 1)'(NUM_SL);

    // Elaboration-time parameter sanity checks.
    if (NUM_SL < 1 || NUM_SL > (1 << SEL_W)) begin : g_bad_num_sl
        $error("syn_lb_addr_dec: NUM_SL must be in 1..2**SEL_W");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("syn_lb_addr_dec: TIMEOUT_CYC must be at least 1");
    end

    lb_dec_fsm_t        state_q,        state_d;
    lb_txn_t            txn_q,          txn_d;
    logic [SEL_W-1:0]   idx_q,          idx_d;
    logic [SLA_W-1:0]   sl_addr_q,      sl_addr_d;
    logic [DATA_W-1:0]  sl_wr_data_q,   sl_wr_data_d;
    logic [NUM_SL-1:0]  sl_rd_en_q,     sl_rd_en_d;
    logic [NUM_SL-1:0]  sl_wr_en_q,     sl_wr_en_d;
    logic               lb_wr_valid_q,  lb_wr_valid_d;
    logic               lb_rd_valid_q,  lb_rd_valid_d;
    logic [DATA_W-1:0]  lb_rd_data_q,   lb_rd_data_d;
    logic               lb_err_q,       lb_err_d;
    logic               lb_busy_q,      lb_busy_d;

`ifdef SYN_LB_DEC_TIMEOUT_EN
    localparam int         CNT_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);
    logic [CNT_W-1:0]      cnt_q,   cnt_d;
    logic [CNT_W-1:0]      cnt_inc;
    assign cnt_inc = cnt_q + CNT_W'(1);
`endif

    logic [SEL_W-1:0]   req_idx;
    logic               req_bad;
    logic [NUM_SL-1:0]  req_onehot;
    logic               sel_ack;
    logic [DATA_W-1:0]  sel_data;

    assign req_idx = lb_addr_i[ADDR_W-1 -: SEL_W];
    assign req_bad = ({1'b0, req_idx} >= NUM_SL_V);

    // One-hot slave select for the incoming request address.
    always_comb begin
        req_onehot = '0;
        for (int k = 0; k < NUM_SL; k++) begin
            if (req_idx == SEL_W'(k)) req_onehot[k] = 1'b1;
        end
    end

    // Pick the captured slave's ack (of the captured type only) and read data.
    always_comb begin
        sel_ack  = 1'b0;
        sel_data = '0;
        for (int k = 0; k < NUM_SL; k++) begin
            if (idx_q == SEL_W'(k)) begin
                sel_ack  = (txn_q == LB_WR) ? sl_wr_valid_i[k] : sl_rd_valid_i[k];
                sel_data = sl_rd_data_i[k*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state and next-output logic of the transaction FSM.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d       = state_q;
        txn_d         = txn_q;
        idx_d         = idx_q;
        sl_addr_d     = sl_addr_q;
        sl_wr_data_d  = sl_wr_data_q;
        lb_rd_data_d  = lb_rd_data_q;
        lb_busy_d     = lb_busy_q;
        sl_rd_en_d    = '0;
        sl_wr_en_d    = '0;
        lb_wr_valid_d = 1'b0;
        lb_rd_valid_d = 1'b0;
        lb_err_d      = 1'b0;
`ifdef SYN_LB_DEC_TIMEOUT_EN
        cnt_d         = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (lb_rd_en_i || lb_wr_en_i) begin
                    // Write wins when both enables arrive together.
                    txn_d        = lb_wr_en_i ? LB_WR : LB_RD;
                    idx_d        = req_idx;
                    sl_addr_d    = lb_addr_i[SLA_W-1:0];
                    sl_wr_data_d = lb_wr_data_i;
                    lb_busy_d    = 1'b1;
                    if (req_bad) begin
                        state_d      = RESP;
                        lb_err_d     = 1'b1;
                        lb_rd_data_d = DATA_W'(LB_ERR_DATA);
                        if (lb_wr_en_i) lb_wr_valid_d = 1'b1;
                        else            lb_rd_valid_d = 1'b1;
                    end else begin
                        state_d = ISSUE;
                        if (lb_wr_en_i) sl_wr_en_d = req_onehot;
                        else            sl_rd_en_d = req_onehot;
                    end
                end
            end
            ISSUE: begin
                state_d = WAIT;
`ifdef SYN_LB_DEC_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            WAIT: begin
                if (sel_ack) begin
                    state_d = RESP;
                    if (txn_q == LB_WR) begin
                        lb_wr_valid_d = 1'b1;
                        lb_rd_data_d  = '0;
                    end else begin
                        lb_rd_valid_d = 1'b1;
                        lb_rd_data_d  = sel_data;
                    end
                end
`ifdef SYN_LB_DEC_TIMEOUT_EN
                else if (cnt_inc == CNT_MAX) begin
                    state_d      = RESP;
                    lb_err_d     = 1'b1;
                    lb_rd_data_d = DATA_W'(LB_ERR_DATA);
                    if (txn_q == LB_WR) lb_wr_valid_d = 1'b1;
                    else                lb_rd_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
`endif
            end
            RESP: begin
                state_d   = IDLE;
                lb_busy_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset abandons any transaction in flight.
    always_ff @(posedge clk_ir or negedge rst_il) begin
        if (!rst_il) begin
            state_q       <= IDLE;
            txn_q         <= LB_RD;
            idx_q         <= '0;
            sl_addr_q     <= '0;
            sl_wr_data_q  <= '0;
            sl_rd_en_q    <= '0;
            sl_wr_en_q    <= '0;
            lb_wr_valid_q <= 1'b0;
            lb_rd_valid_q <= 1'b0;
            lb_rd_data_q  <= '0;
            lb_err_q      <= 1'b0;
            lb_busy_q     <= 1'b0;
`ifdef SYN_LB_DEC_TIMEOUT_EN
            cnt_q         <= '0;
`endif
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values of the others.
            state_q       <= state_d;
            txn_q         <= txn_d;
            idx_q         <= idx_d;
            sl_addr_q     <= sl_addr_d;
            sl_wr_data_q  <= sl_wr_data_d;
            sl_rd_en_q    <= sl_rd_en_d;
            sl_wr_en_q    <= sl_wr_en_d;
            lb_wr_valid_q <= lb_wr_valid_d;
            lb_rd_valid_q <= lb_rd_valid_d;
            lb_rd_data_q  <= lb_rd_data_d;
            lb_err_q      <= lb_err_d;
            lb_busy_q     <= lb_busy_d;
`ifdef SYN_LB_DEC_TIMEOUT_EN
            cnt_q         <= cnt_d;
`endif
        end
    end

    assign lb_wr_valid_o = lb_wr_valid_q;
    assign lb_rd_valid_o = lb_rd_valid_q;
    assign lb_rd_data_o  = lb_rd_data_q;
    assign lb_err_o      = lb_err_q;
    assign lb_busy_o     = lb_busy_q;
    assign sl_rd_en_o    = sl_rd_en_q;
    assign sl_wr_en_o    = sl_wr_en_q;
    assign sl_addr_o     = sl_addr_q;
    assign sl_wr_data_o  = sl_wr_data_q;

endmodule : syn_lb_addr_dec

// File: tb/tb_syn_lb_addr_dec.sv
// tb_syn_lb_addr_dec: directed, table-driven bench for syn_lb_addr_dec.
// Honours SYN_LB_DEC_TIMEOUT_EN (timeout expected after TIMEOUT_CYC=8 WAIT cycles).
module tb_syn_lb_addr_dec;

    localparam int DATA_W      = 32;
    localparam int ADDR_W      = 12;
    localparam int SEL_W       = 4;
    localparam int NUM_SL      = 4;
    localparam int TIMEOUT_CYC = 8;
    localparam int SLA_W       = ADDR_W - SEL_W;

    logic                      clk_ir = 1'b0;
    logic                      rst_il = 1'b0;
    logic                      lb_rd_en_i = 1'b0;
    logic                      lb_wr_en_i = 1'b0;
    logic [ADDR_W-1:0]         lb_addr_i = '0;
    logic [DATA_W-1:0]         lb_wr_data_i = '0;
    logic                      lb_wr_valid_o;
    logic                      lb_rd_valid_o;
    logic [DATA_W-1:0]         lb_rd_data_o;
    logic                      lb_err_o;
    logic                      lb_busy_o;
    logic [NUM_SL-1:0]         sl_rd_en_o;
    logic [NUM_SL-1:0]         sl_wr_en_o;
    logic [SLA_W-1:0]          sl_addr_o;
    logic [DATA_W-1:0]         sl_wr_data_o;
    logic [NUM_SL-1:0]         sl_wr_valid_i = '0;
    logic [NUM_SL-1:0]         sl_rd_valid_i = '0;
    logic [NUM_SL*DATA_W-1:0]  sl_rd_data_i = '0;

    syn_lb_addr_dec #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .SEL_W(SEL_W),
        .NUM_SL(NUM_SL), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk_ir(clk_ir), .rst_il(rst_il),
        .lb_rd_en_i(lb_rd_en_i), .lb_wr_en_i(lb_wr_en_i),
        .lb_addr_i(lb_addr_i), .lb_wr_data_i(lb_wr_data_i),
        .lb_wr_valid_o(lb_wr_valid_o), .lb_rd_valid_o(lb_rd_valid_o),
        .lb_rd_data_o(lb_rd_data_o), .lb_err_o(lb_err_o), .lb_busy_o(lb_busy_o),
        .sl_rd_en_o(sl_rd_en_o), .sl_wr_en_o(sl_wr_en_o),
        .sl_addr_o(sl_addr_o), .sl_wr_data_o(sl_wr_data_o),
        .sl_wr_valid_i(sl_wr_valid_i), .sl_rd_valid_i(sl_rd_valid_i),
        .sl_rd_data_i(sl_rd_data_i)
    );

    always #5 clk_ir = ~clk_ir;

    typedef struct {
        logic              rd;
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        int                ack_dly;    // WAIT cycle (0-based) in which the slave acks
        logic              noise;      // drive unrelated valids in the first WAIT cycle
        logic [DATA_W-1:0] sl_data;    // read data offered by the addressed slave
        logic [NUM_SL-1:0] exp_rd_en;
        logic [NUM_SL-1:0] exp_wr_en;
        int                exp_lat;    // cycles from request to lb valid
        logic              exp_err;
        logic [DATA_W-1:0] exp_data;
    } vec_t;

    localparam int NVEC = 9;
    vec_t vecs[NVEC];

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Advance one clock; outputs are then read 1 time unit after the edge.
    task automatic step();
        @(posedge clk_ir);
        #1;
    endtask

    task automatic run_txn(input vec_t v, input int id);
        int idx;
        int resp_step;
        logic good;
        idx       = int'(v.addr[ADDR_W-1 -: SEL_W]);
        good      = (idx < NUM_SL);
        resp_step = -1;
        for (int k = 0; k < NUM_SL; k++)
            sl_rd_data_i[k*DATA_W +: DATA_W] = 32'hA5A5_0000 | 32'(k);
        if (good) sl_rd_data_i[idx*DATA_W +: DATA_W] = v.sl_data;
        lb_rd_en_i   = v.rd;
        lb_wr_en_i   = v.wr;
        lb_addr_i    = v.addr;
        lb_wr_data_i = v.wdata;
        for (int s = 1; s <= 20 && resp_step < 0; s++) begin
            step();
            if (s == 1) begin
                lb_rd_en_i = 1'b0;
                lb_wr_en_i = 1'b0;
                check($sformatf("v%0d_sl_rd_en", id), 64'(sl_rd_en_o), 64'(v.exp_rd_en));
                check($sformatf("v%0d_sl_wr_en", id), 64'(sl_wr_en_o), 64'(v.exp_wr_en));
                check($sformatf("v%0d_busy", id), 64'(lb_busy_o), 64'(1));
                if (good) check($sformatf("v%0d_sl_addr", id), 64'(sl_addr_o), 64'(v.addr[SLA_W-1:0]));
                if (good && v.wr) check($sformatf("v%0d_sl_wdata", id), 64'(sl_wr_data_o), 64'(v.wdata));
            end
            if (s == 2)
                check($sformatf("v%0d_en_one_cycle", id), 64'({sl_rd_en_o, sl_wr_en_o}), 64'(0));
            if (lb_rd_valid_o || lb_wr_valid_o) begin
                resp_step = s;
            end else begin
                sl_rd_valid_i = '0;
                sl_wr_valid_i = '0;
                if (good && s == 2 + v.ack_dly) begin
                    if (v.wr) sl_wr_valid_i[idx] = 1'b1;
                    else      sl_rd_valid_i[idx] = 1'b1;
                end else if (good && s == 2 && v.noise) begin
                    // Other slaves, and the wrong type on the right slave.
                    sl_rd_valid_i = '1;
                    sl_wr_valid_i = '1;
                    if (v.wr) sl_wr_valid_i[idx] = 1'b0;
                    else      sl_rd_valid_i[idx] = 1'b0;
                end
            end
        end
        sl_rd_valid_i = '0;
        sl_wr_valid_i = '0;
        check($sformatf("v%0d_latency", id), 64'(resp_step), 64'(v.exp_lat));
        check($sformatf("v%0d_kind", id), 64'({lb_rd_valid_o, lb_wr_valid_o}), v.wr ? 64'(1) : 64'(2));
        check($sformatf("v%0d_err", id), 64'(lb_err_o), 64'(v.exp_err));
        check($sformatf("v%0d_rd_data", id), 64'(lb_rd_data_o), 64'(v.exp_data));
        step();
        check($sformatf("v%0d_after", id), 64'({lb_rd_valid_o, lb_wr_valid_o, lb_busy_o}), 64'(0));
        check($sformatf("v%0d_hold", id), 64'(lb_rd_data_o), 64'(v.exp_data));
        step();
    endtask

    initial begin
        int spurious;

        //          rd    wr    addr     wdata          dly noise sl_data        rd_en    wr_en    lat err   data
        vecs[0] = '{1'b0, 1'b1, 12'h205, 32'hCAFE_F00D, 2, 1'b1, 32'h0,         4'b0000, 4'b0100, 5, 1'b0, 32'h0};
        vecs[1] = '{1'b1, 1'b0, 12'h1FF, 32'h0,         0, 1'b0, 32'h1234_5678, 4'b0010, 4'b0000, 3, 1'b0, 32'h1234_5678};
        vecs[2] = '{1'b1, 1'b0, 12'h7AA, 32'h0,         0, 1'b0, 32'h0,         4'b0000, 4'b0000, 1, 1'b1, 32'h0};
        vecs[3] = '{1'b1, 1'b0, 12'h3C4, 32'h0,         1, 1'b1, 32'hDEAD_BEEF, 4'b1000, 4'b0000, 4, 1'b0, 32'hDEAD_BEEF};
        vecs[4] = '{1'b0, 1'b1, 12'h0FF, 32'h0BAD_F00D, 0, 1'b0, 32'h0,         4'b0000, 4'b0001, 3, 1'b0, 32'h0};
        vecs[5] = '{1'b1, 1'b0, 12'h002, 32'h0,         3, 1'b1, 32'h0000_0001, 4'b0001, 4'b0000, 6, 1'b0, 32'h0000_0001};
        vecs[6] = '{1'b1, 1'b0, 12'h400, 32'h0,         0, 1'b0, 32'h0,         4'b0000, 4'b0000, 1, 1'b1, 32'h0};
        vecs[7] = '{1'b0, 1'b1, 12'hF00, 32'h1111_2222, 0, 1'b0, 32'h0,         4'b0000, 4'b0000, 1, 1'b1, 32'h0};
        vecs[8] = '{1'b1, 1'b0, 12'h3FF, 32'h0,         0, 1'b0, 32'h8000_0000, 4'b1000, 4'b0000, 3, 1'b0, 32'h8000_0000};

        // Reset state
        #2;
        check("reset_outputs",
              64'({lb_wr_valid_o, lb_rd_valid_o, lb_err_o, lb_busy_o, sl_rd_en_o, sl_wr_en_o}), 64'(0));
        check("reset_data", 64'({lb_rd_data_o, sl_addr_o} | 64'(sl_wr_data_o)), 64'(0));
        step();
        step();
        #4 rst_il = 1'b1;
        step();

        for (int i = 0; i < NVEC; i++) run_txn(vecs[i], i);

        // Both enables together: write wins; a read issued while busy is dropped.
        lb_rd_en_i   = 1'b1;
        lb_wr_en_i   = 1'b1;
        lb_addr_i    = 12'h010;
        lb_wr_data_i = 32'h55AA_55AA;
        step();
        lb_rd_en_i = 1'b0;
        lb_wr_en_i = 1'b0;
        check("both_wr_en", 64'(sl_wr_en_o), 64'(4'b0001));
        check("both_rd_en", 64'(sl_rd_en_o), 64'(0));
        check("both_addr", 64'(sl_addr_o), 64'(8'h10));
        check("both_wdata", 64'(sl_wr_data_o), 64'(32'h55AA_55AA));
        step();
        lb_rd_en_i = 1'b1;
        lb_addr_i  = 12'h1FF;
        step();
        lb_rd_en_i = 1'b0;
        check("busy_rd_no_pulse", 64'({sl_rd_en_o, sl_wr_en_o}), 64'(0));
        sl_wr_valid_i[0] = 1'b1;
        step();
        sl_wr_valid_i = '0;
        check("both_resp", 64'({lb_rd_valid_o, lb_wr_valid_o, lb_err_o}), 64'(3'b010));
        spurious = 0;
        for (int s = 0; s < 10; s++) begin
            step();
            if (lb_rd_valid_o || lb_wr_valid_o || lb_busy_o || (|sl_rd_en_o)) spurious++;
        end
        check("dropped_rd_silent", 64'(spurious), 64'(0));

        // Slave never acks.
        lb_rd_en_i = 1'b1;
        lb_addr_i  = 12'h105;
        lb_wr_data_i = 32'h0000_1234;
        step();
        lb_rd_en_i = 1'b0;
        check("stall_issue", 64'(sl_rd_en_o), 64'(4'b0010));
`ifdef SYN_LB_DEC_TIMEOUT_EN
        // ISSUE seen at step 1, WAIT cycles at steps 2..9, timeout RESP at step 10.
        begin
            int resp_step;
            resp_step = -1;
            for (int s = 2; s <= 30 && resp_step < 0; s++) begin
                step();
                if (lb_rd_valid_o || lb_wr_valid_o) resp_step = s;
            end
            check("timeout_latency", 64'(resp_step), 64'(TIMEOUT_CYC + 2));
            check("timeout_resp", 64'({lb_rd_valid_o, lb_err_o}), 64'(2'b11));
            check("timeout_data", 64'(lb_rd_data_o), 64'(0));
            step();
        end
        // Start another read and leave it in WAIT for the reset case.
        lb_rd_en_i = 1'b1;
        lb_addr_i  = 12'h105;
        step();
        lb_rd_en_i = 1'b0;
        step();
`else
        spurious = 0;
        for (int s = 0; s < 20; s++) begin
            step();
            if (lb_rd_valid_o || lb_wr_valid_o || !lb_busy_o) spurious++;
        end
        check("stall_busy_held", 64'(spurious), 64'(0));
`endif

        // Reset in WAIT: outputs clear at once; a late slave ack is ignored.
        rst_il = 1'b0;
        #1;
        check("midrst_flags",
              64'({lb_wr_valid_o, lb_rd_valid_o, lb_err_o, lb_busy_o, sl_rd_en_o, sl_wr_en_o}), 64'(0));
        check("midrst_addr", 64'(sl_addr_o), 64'(0));
        check("midrst_wdata", 64'(sl_wr_data_o), 64'(0));
        #2 rst_il = 1'b1;
        step();
        sl_rd_valid_i[1] = 1'b1;
        step();
        step();
        sl_rd_valid_i = '0;
        spurious = 0;
        for (int s = 0; s < 4; s++) begin
            if (lb_rd_valid_o || lb_wr_valid_o || lb_busy_o) spurious++;
            step();
        end
        check("late_ack_ignored", 64'(spurious), 64'(0));

        // Decoder still works after the abandoned transaction.
        run_txn(vecs[1], 100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_syn_lb_addr_dec
